// File: rtl/ahb_lite_sram_responder_if.sv
// rtl/ahb_lite_sram_responder_if.sv - AHB-Lite bus bundle between initiator/mux and the SRAM responder
interface ahb_lite_sram_responder_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_lite_sram_responder.sv
// rtl/ahb_lite_sram_responder.sv - AHB-Lite flop-memory slave with wait states, lane strobes and two-cycle ERROR
module ahb_lite_sram_responder #(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input logic                        HCLK,
  input logic                        HRESET,
  ahb_lite_sram_responder_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  state_t          state;
  logic [3:0]      wait_cnt;
  logic [31:0]     mem [DEPTH];
  logic            hready_q;
  logic            hresp_q;
  logic            ph_valid;
  logic            ph_write;
  logic [AW-1:0]   ph_idx;
  logic [1:0]      ph_lane;
  logic [2:0]      ph_size;
  logic            accept;
  logic            addr_err;
  logic            do_commit;
  logic [3:0]      lane_en;
  logic [31:0]     lane_mask;
  logic            unused_bits;

  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] & hready_q;

  always_comb begin
    addr_err = 1'b0;
    case (bus.HSIZE)
      3'b000:  addr_err = 1'b0;
      3'b001:  addr_err = bus.HADDR[0];
      3'b010:  addr_err = (bus.HADDR[1:0] != 2'b00);
      default: addr_err = 1'b1;
    endcase
    if (32'(bus.HADDR[15:2]) >= 32'(DEPTH)) addr_err = 1'b1;
  end

  always_comb begin
    lane_en = 4'b0000;
    case (ph_size)
      3'b000:  lane_en = 4'b0001 << ph_lane;
      3'b001:  lane_en = ph_lane[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  assign lane_mask = {{8{lane_en[3]}}, {8{lane_en[2]}}, {8{lane_en[1]}}, {8{lane_en[0]}}};

  // IDLE with a live phase is the completing cycle of an OKAY transfer
  assign do_commit = ph_valid & ph_write & hready_q & (state == IDLE);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      ph_valid <= 1'b0;
      ph_write <= 1'b0;
      ph_idx   <= '0;
      ph_lane  <= 2'b00;
      ph_size  <= 3'b000;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else begin
      if (do_commit) mem[ph_idx] <= (mem[ph_idx] & ~lane_mask) | (bus.HWDATA & lane_mask);
      case (state)
        IDLE, ERR2: begin
          state    <= IDLE;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
          ph_valid <= 1'b0;
          if (accept) begin
            ph_write <= bus.HWRITE;
            ph_idx   <= bus.HADDR[AW+1:2];
            ph_lane  <= bus.HADDR[1:0];
            ph_size  <= bus.HSIZE;
            if (addr_err) begin
              state    <= ERR1;
              hready_q <= 1'b0;
              hresp_q  <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state    <= WAIT;
              hready_q <= 1'b0;
              wait_cnt <= 4'(WAIT_STATES - 1);
              ph_valid <= 1'b1;
            end else begin
              ph_valid <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state    <= IDLE;
            hready_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ERR1: begin
          state    <= ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.HREADYOUT = hready_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = (ph_valid & ~ph_write) ? mem[ph_idx] : 32'd0;

  assign unused_bits = ^{bus.HADDR[31:16], bus.HTRANS[0]};
endmodule

// File: tb/tb_ahb_lite_sram_responder.sv
// tb/tb_ahb_lite_sram_responder.sv - self-checking bench for ahb_lite_sram_responder (WAIT_STATES 0 and 1)
module tb_ahb_lite_sram_responder;
  localparam int DEPTH = 16;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        sel0, sel1;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [1:0]  rdy, rsp;
  logic [31:0] rdat [2];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_sram_responder_if bus_w0 ();
  ahb_lite_sram_responder_if bus_w1 ();

  assign bus_w0.HSEL = sel0;     assign bus_w1.HSEL = sel1;
  assign bus_w0.HADDR = haddr;   assign bus_w1.HADDR = haddr;
  assign bus_w0.HTRANS = htrans; assign bus_w1.HTRANS = htrans;
  assign bus_w0.HSIZE = hsize;   assign bus_w1.HSIZE = hsize;
  assign bus_w0.HWRITE = hwrite; assign bus_w1.HWRITE = hwrite;
  assign bus_w0.HWDATA = hwdata; assign bus_w1.HWDATA = hwdata;
  assign bus_w0.HREADY = bus_w0.HREADYOUT;
  assign bus_w1.HREADY = bus_w1.HREADYOUT;
  assign rdy = {bus_w1.HREADYOUT, bus_w0.HREADYOUT};
  assign rsp = {bus_w1.HRESP, bus_w0.HRESP};
  assign rdat[0] = bus_w0.HRDATA;
  assign rdat[1] = bus_w1.HRDATA;

  ahb_lite_sram_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus_w0));
  ahb_lite_sram_responder #(.DEPTH(DEPTH), .WAIT_STATES(1)) dut1 (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus_w1));

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  // Model: per DUT k (WAIT_STATES = k), a pending data phase with cycles left until it completes
  logic [31:0] mmem [2][DEPTH];
  bit          cv [2];
  bit          cerr [2];
  bit          cwr [2];
  int          cidx [2];
  logic [3:0]  clanes [2];
  int          cleft [2];

  function automatic bit exp_ready(int k);
    return !cv[k] || cleft[k] == 1;
  endfunction

  function automatic logic [31:0] exp_rdata(int k);
    return (cv[k] && !cerr[k] && !cwr[k]) ? mmem[k][cidx[k]] : 32'd0;
  endfunction

  always @(posedge HCLK) begin
    for (int k = 0; k < 2; k++) begin
      bit r, s, bad;
      int a;
      if (HRESET) begin
        cv[k] = 0;
        for (int i = 0; i < DEPTH; i++) mmem[k][i] = 32'd0;
      end else begin
        r = exp_ready(k);
        if (cv[k] && r && !cerr[k] && cwr[k])
          for (int b = 0; b < 4; b++)
            if (clanes[k][b]) mmem[k][cidx[k]][8*b +: 8] = hwdata[8*b +: 8];
        if (r) begin
          s = (k == 0) ? sel0 : sel1;
          if (s && htrans[1]) begin
            a   = int'(haddr[15:0]);
            bad = (hsize > 3'd2) || (hsize == 3'd1 && a % 2 != 0) ||
                  (hsize == 3'd2 && a % 4 != 0) || (a / 4 >= DEPTH);
            cv[k]    = 1;
            cerr[k]  = bad;
            cwr[k]   = hwrite;
            cidx[k]  = a / 4;
            clanes[k] = (hsize == 3'd0) ? 4'(1 << (a % 4)) :
                        (hsize == 3'd1) ? ((a % 4 >= 2) ? 4'b1100 : 4'b0011) : 4'b1111;
            cleft[k] = bad ? 2 : 1 + k;
          end else begin
            cv[k] = 0;
          end
        end else begin
          cleft[k]--;
        end
      end
    end
  end

  always @(negedge HCLK) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("cyc_hreadyout%0d", k), 32'(rdy[k]), 32'(exp_ready(k)));
        check($sformatf("cyc_hresp%0d", k), 32'(rsp[k]), 32'(cv[k] && cerr[k]));
        check($sformatf("cyc_hrdata%0d", k), rdat[k], exp_rdata(k));
      end
    end
  end

  task automatic set_sel(input int k, input logic v);
    if (k == 0) sel0 = v; else sel1 = v;
  endtask

  task automatic xfer(input int k, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wd, output logic [31:0] rd, output logic resp, output int stalls);
    int guard;
    set_sel(k, 1'b1);
    htrans = 2'b10; haddr = addr; hsize = size; hwrite = wr;
    @(posedge HCLK); #1;
    set_sel(k, 1'b0);
    htrans = 2'b00; hwdata = wd;
    stalls = 0; guard = 0;
    while (rdy[k] == 1'b0 && guard < 40) begin
      stalls++; guard++;
      @(posedge HCLK); #1;
    end
    if (guard >= 40) check("xfer_timeout", 32'(guard), 32'd0);
    rd = rdat[k]; resp = rsp[k];
    @(posedge HCLK); #1;
  endtask

  logic [31:0] rd;
  logic        resp;
  int          st;

  initial begin
    HRESET = 1'b1; sel0 = 0; sel1 = 0; haddr = 0; hwdata = 0; htrans = 0; hsize = 0; hwrite = 0;
    @(posedge HCLK); #1;
    chk_en = 1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    check("reset_hreadyout", 32'(rdy), 32'h3);
    check("reset_hresp", 32'(rsp), 32'h0);
    check("reset_hrdata", rdat[1], 32'h0);

    // T1: one stall per phase with WAIT_STATES=1
    xfer(1, 1, 32'h4000_0020, 3'd2, 32'h000D_EEEE, rd, resp, st);
    check("t1_wr_stalls", 32'(st), 32'd1);
    check("t1_wr_resp", 32'(resp), 32'd0);
    xfer(1, 0, 32'h4000_0020, 3'd2, 32'h0, rd, resp, st);
    check("t1_rd_stalls", 32'(st), 32'd1);
    check("t1_rd_data", rd, 32'h000D_EEEE);
    check("t1_rd_resp", 32'(resp), 32'd0);

    // T2: byte and halfword lane strobes
    xfer(1, 1, 32'h4000_0020, 3'd2, 32'h1122_3344, rd, resp, st);
    xfer(1, 1, 32'h4000_0021, 3'd0, 32'h0000_AA00, rd, resp, st);
    xfer(1, 0, 32'h4000_0020, 3'd2, 32'h0, rd, resp, st);
    check("t2_byte", rd, 32'h1122_AA44);
    xfer(1, 1, 32'h4000_0022, 3'd1, 32'hBEEF_0000, rd, resp, st);
    xfer(1, 0, 32'h4000_0020, 3'd2, 32'h0, rd, resp, st);
    check("t2_half", rd, 32'hBEEF_AA44);

    // T3: error responses leave memory untouched
    xfer(1, 0, 32'h4000_0040, 3'd2, 32'h0, rd, resp, st);
    check("t3_oob_resp", 32'(resp), 32'd1);
    check("t3_oob_stalls", 32'(st), 32'd1);
    check("t3_oob_data", rd, 32'h0);
    xfer(1, 1, 32'h4000_0022, 3'd2, 32'hDEAD_BEEF, rd, resp, st);
    check("t3_misalign_resp", 32'(resp), 32'd1);
    xfer(1, 1, 32'h4000_0021, 3'd1, 32'hDEAD_BEEF, rd, resp, st);
    check("t3_half_misalign_resp", 32'(resp), 32'd1);
    xfer(1, 1, 32'h4000_0020, 3'd3, 32'hDEAD_BEEF, rd, resp, st);
    check("t3_size_resp", 32'(resp), 32'd1);
    xfer(1, 0, 32'h4000_0020, 3'd2, 32'h0, rd, resp, st);
    check("t3_mem_kept", rd, 32'hBEEF_AA44);
    xfer(1, 1, 32'h4000_003C, 3'd2, 32'hCAFE_0001, rd, resp, st);
    check("t3_last_word_resp", 32'(resp), 32'd0);
    xfer(1, 0, 32'h4000_003C, 3'd2, 32'h0, rd, resp, st);
    check("t3_last_word_data", rd, 32'hCAFE_0001);

    // T4: pipelined write then read, zero wait states
    sel0 = 1; htrans = 2'b10; haddr = 32'h0; hsize = 3'd2; hwrite = 1;
    @(posedge HCLK); #1;
    check("t4_wr_ready", 32'(rdy[0]), 32'd1);
    hwrite = 0; hwdata = 32'h5;
    @(posedge HCLK); #1;
    sel0 = 0; htrans = 2'b00;
    check("t4_rd_ready", 32'(rdy[0]), 32'd1);
    check("t4_rd_data", rdat[0], 32'h0000_0005);
    @(posedge HCLK); #1;

    // T5: BUSY while selected, NONSEQ while deselected
    sel1 = 1; htrans = 2'b01; haddr = 32'h4000_0020; hsize = 3'd2; hwrite = 1; hwdata = 32'hFFFF_FFFF;
    @(posedge HCLK); #1;
    check("t5_busy_ready", 32'(rdy[1]), 32'd1);
    check("t5_busy_resp", 32'(rsp[1]), 32'd0);
    sel1 = 0; htrans = 2'b10;
    @(posedge HCLK); #1;
    check("t5_nosel_ready", 32'(rdy[1]), 32'd1);
    htrans = 2'b00;
    @(posedge HCLK); #1;
    xfer(1, 0, 32'h4000_0020, 3'd2, 32'h0, rd, resp, st);
    check("t5_mem_kept", rd, 32'hBEEF_AA44);

    // T6: reset during the wait state of a write
    sel1 = 1; htrans = 2'b10; haddr = 32'h4000_0004; hsize = 3'd2; hwrite = 1;
    @(posedge HCLK); #1;
    sel1 = 0; htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
    check("t6_in_wait", 32'(rdy[1]), 32'd0);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    check("t6_rst_ready", 32'(rdy[1]), 32'd1);
    check("t6_rst_resp", 32'(rsp[1]), 32'd0);
    check("t6_rst_data", rdat[1], 32'd0);
    xfer(1, 0, 32'h4000_0004, 3'd2, 32'h0, rd, resp, st);
    check("t6_rd_after_rst", rd, 32'h0);
    xfer(1, 0, 32'h4000_0020, 3'd2, 32'h0, rd, resp, st);
    check("t6_mem_cleared", rd, 32'h0);

    repeat (2) @(posedge HCLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
